uart_frame_sender: RTL

UART_FRAME_SENDER -- requirements
Module: uart_frame_sender

---
 rtl/uart_frame_sender.sv | 137 +++++++++++++
 1 files changed

// File: rtl/uart_frame_sender.sv
// uart_frame_sender: serialises a 64-byte frame as 8N1 UART characters,
// byte 0 first, with no idle time between characters.
//
// Handshake: a frame is accepted on any rising clk edge where
// frame_valid && frame_ready. frame_ready is high only while the FSM is IDLE.
// frame_valid is ignored at all other times. The frame is copied into an
// internal register on acceptance, so frame_cube_flat may change afterwards.
module uart_frame_sender #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [511:0] frame_cube_flat,
  input  logic         frame_valid,
  output logic         frame_ready,
  output logic         tx,
  output logic         frame_done,
  output logic         busy,
  output logic [1:0]   dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

  state_t         state_q, state_d;
  logic [511:0]   frame_q, frame_d;
  logic [5:0]     byte_idx_q, byte_idx_d;
  logic [2:0]     bit_idx_q, bit_idx_d;
  logic [15:0]    baud_cnt_q, baud_cnt_d;
  logic           tx_q, tx_d;
  logic           done_q, done_d;

  logic           bit_end;
  logic [7:0]     cur_byte;

  // Last cycle of the current bit time; every bit lasts BAUD_LAST+1 cycles.
  assign bit_end  = (baud_cnt_q == BAUD_LAST);
  // Byte currently on the line, selected by the byte index.
  assign cur_byte = frame_q[{byte_idx_q, 3'b000} +: 8];

  assign frame_ready = (state_q == IDLE);
  assign busy        = ~frame_ready;
  assign tx          = tx_q;
  assign frame_done  = done_q;
  assign dbg_state   = state_q;

  // Next-state and next-output logic. tx_d is the level the line will carry
  // during the bit that begins after the coming edge, so tx is registered.
  always_comb begin
    state_d    = state_q;
    frame_d    = frame_q;
    byte_idx_d = byte_idx_q;
    bit_idx_d  = bit_idx_q;
    tx_d       = tx_q;
    done_d     = 1'b0;
    baud_cnt_d = bit_end ? 16'd0 : baud_cnt_q + 16'd1;

    case (state_q)
      IDLE: begin
        baud_cnt_d = 16'd0;
        tx_d       = 1'b1;
        if (frame_valid) begin
          frame_d    = frame_cube_flat;
          state_d    = START;
          byte_idx_d = 6'd0;
          bit_idx_d  = 3'd0;
          tx_d       = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          state_d   = DATA;
          bit_idx_d = 3'd0;
          tx_d      = cur_byte[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            tx_d      = cur_byte[bit_idx_q + 3'd1];
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          if (byte_idx_q == 6'd63) begin
            // Last character done: the frame ends here instead of wrapping.
            state_d    = IDLE;
            byte_idx_d = 6'd0;
            tx_d       = 1'b1;
            done_d     = 1'b1;
          end else begin
            state_d    = START;
            byte_idx_d = byte_idx_q + 6'd1;
            tx_d       = 1'b0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  // State, counters and registered outputs. Reset aborts any frame in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      frame_q    <= '0;
      byte_idx_q <= 6'd0;
      bit_idx_q  <= 3'd0;
      baud_cnt_q <= 16'd0;
      tx_q       <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      frame_q    <= frame_d;
      byte_idx_q <= byte_idx_d;
      bit_idx_q  <= bit_idx_d;
      baud_cnt_q <= baud_cnt_d;
      tx_q       <= tx_d;
      done_q     <= done_d;
    end
  end

endmodule
